// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among functional units,
// one registered broadcast per cycle plus a saturating grant counter.
module cdb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int LOCK_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*LOCK_W-1:0]   req_index,
  input  logic [N_REQ*DATA_W-1:0]   req_result,
  output logic [N_REQ-1:0]          req_done,
  output logic                      cdb_valid,
  output logic [LOCK_W-1:0]         cdb_index,
  output logic [DATA_W-1:0]         cdb_result,
  output logic [15:0]               grant_cnt
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  done;
  logic              found;
  logic              grant;
  logic [PW-1:0]     win;
  int                j;

  logic              valid_q, valid_d;
  logic [LOCK_W-1:0] index_q, index_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [15:0]       cnt_q, cnt_d;

  // Lock index 0 means the unit holds no rename lock, so it never wins.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = req_valid[i] &&
                (req_index[i*LOCK_W +: LOCK_W] != '0);
    end
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && elig[j]) begin
        found = 1'b1;
        win   = PW'(j);
      end
    end
    grant = found && !rst && !flush;
    done  = '0;
    if (grant) done[win] = 1'b1;
  end

  always_comb begin
    valid_d  = grant;
    index_d  = index_q;
    result_d = result_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    if (grant) begin
      index_d  = req_index[int'(win)*LOCK_W +: LOCK_W];
      result_d = req_result[int'(win)*DATA_W +: DATA_W];
      rr_d     = (int'(win) == N_REQ-1) ? '0 : win + PW'(1);
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      index_q  <= '0;
      result_q <= '0;
      rr_q     <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      index_q  <= index_d;
      result_q <= result_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_done   = done;
  assign cdb_valid  = valid_q;
  assign cdb_index  = index_q;
  assign cdb_result = result_q;
  assign grant_cnt  = cnt_q;

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter N_REQ, default 3, number of functional units sharing the CDB (0=ALU, 1=LSU, 2=BRU).
REQ-002 Parameter LOCK_W, default 5, width of a rename lock index; index 0 means "no lock".
REQ-003 Parameter DATA_W, default 32, result width.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  pipeline flush; suppresses grants and clears the bus register.
REQ-007 req_valid  input  N_REQ  unit i has a finished result to broadcast.
REQ-008 req_index  input  N_REQ*LOCK_W  lock index of unit i, slice [i*LOCK_W +: LOCK_W].
REQ-009 req_result  input  N_REQ*DATA_W  result of unit i, slice [i*DATA_W +: DATA_W].
REQ-010 req_done  output  N_REQ  one-hot grant; unit i retires its entry at the next edge.
REQ-011 cdb_valid  output  1  broadcast valid.
REQ-012 cdb_index  output  LOCK_W  broadcast lock index.
REQ-013 cdb_result  output  DATA_W  broadcast result.
REQ-014 grant_cnt  output  16  total broadcasts since reset, saturating.

Function
REQ-015 Request i eligible in a cycle iff req_valid[i]=1 and its req_index != 0; zero-index requests are ignored, never granted.
REQ-016 Arbitration combinational, round-robin: search starts at rr_ptr, ascending with wrap at N_REQ; first eligible unit wins.
REQ-017 req_done is one-hot of the winner in the same cycle as the request; all zero when no eligible request, flush=1, or rst=1.
REQ-018 At most one req_done bit high in any cycle.
REQ-019 On a grant, at the next edge: cdb_valid<=1, cdb_index<=winner index, cdb_result<=winner result (latency: request cycle t -> broadcast cycle t+1, one cycle wide).
REQ-020 No grant in cycle t -> cdb_valid=0 in t+1; cdb_index/cdb_result hold previous values.
REQ-021 On a grant, rr_ptr <= (winner+1) mod N_REQ; otherwise rr_ptr holds.
REQ-022 Requester holding req_valid without receiving req_done keeps its data stable; arbiter stores no request data other than the bus register.
REQ-023 Sustained throughput: one broadcast per cycle when any eligible request is present every cycle.
REQ-024 Fairness: a continuously eligible unit is granted within N_REQ cycles.
REQ-025 flush=1 in cycle t: no grant, cdb_valid=0 in t+1, rr_ptr unchanged; flush overrides any simultaneous request.
REQ-026 grant_cnt increments by 1 per grant, saturates at 16'hFFFF.
REQ-027 A unit may deassert req_valid before being granted (e.g. its own flush); no grant or broadcast is produced for it.

Reset
REQ-028 rst=1 at an edge: cdb_valid=0, cdb_index=0, cdb_result=0, rr_ptr=0, grant_cnt=0.
REQ-029 rst=1 mid-operation: req_done forced 0 in that cycle; a pending request is not broadcast; first grant after reset goes to lowest-index eligible unit.

Verification
REQ-030 After reset, only unit 1 valid, index 7, result 0x0000_00AB -> req_done=3'b010 same cycle; next cycle cdb_valid=1, cdb_index=7, cdb_result=0xAB; following cycle cdb_valid=0 if unit 1 dropped.
REQ-031 All three units held valid for 6 cycles from reset -> grant order 0,1,2,0,1,2; cdb_valid=1 for 6 consecutive cycles; grant_cnt=6.
REQ-032 Unit 0 valid with index 0, unit 2 valid with index 3 -> req_done=3'b100, broadcast index 3; unit 0 never granted.
REQ-033 Units 0 and 2 valid, flush=1 same cycle -> req_done=0, cdb_valid=0 next cycle, rr_ptr unchanged; flush released -> unit 0 granted first.
REQ-034 Unit 2 granted (rr_ptr=0), rst asserted next cycle with units 0,1 valid -> no req_done, cdb_valid=0 after reset edge, grant_cnt=0, first post-reset grant to unit 0.
REQ-035 Force grant_cnt to 16'hFFFE, issue 3 grants -> grant_cnt stays 16'hFFFF.
